// File: rtl/cam_capture_pkg.sv
// Shared types and FIFO entry layout for the DVP camera capture front end.
package cam_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SKIP   = 2'd1,
        ST_ACTIVE = 2'd2
    } cap_state_e;

    localparam int unsigned AXIS_USER_W = 1;
    localparam int unsigned AXIS_LAST_W = 1;

    // Entry layout, LSB first: last, user, then 8*BYTES_PER_PIXEL data bits.
    localparam int unsigned ENTRY_LAST_BIT = 0;
    localparam int unsigned ENTRY_USER_BIT = ENTRY_LAST_BIT + AXIS_LAST_W;
    localparam int unsigned ENTRY_DATA_LSB = ENTRY_USER_BIT + AXIS_USER_W;

    function automatic int unsigned entry_width(input int unsigned bytes_per_pixel);
        return 8 * bytes_per_pixel + AXIS_USER_W + AXIS_LAST_W;
    endfunction

endpackage

// File: rtl/cam_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush.
module cam_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             i_pclk,
    input  logic             i_resetn,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_pclk or negedge i_resetn) begin
        if (!i_resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_pclk) begin
        if (do_push && !i_flush) mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/cam_capture_maxis_fifo.sv
// DVP sensor capture: byte-to-pixel assembly, frame decimation and error tracking,
// delivered through an elastic FIFO onto an AXI4-Stream video master.
module cam_capture_maxis_fifo
    import cam_capture_pkg::*;
#(
    parameter int unsigned X_RES           = 640,
    parameter int unsigned Y_RES           = 480,
    parameter int unsigned BYTES_PER_PIXEL = 2,
    parameter int unsigned BYTE_ORDER      = 0,
    parameter int unsigned FIFO_DEPTH      = 16
) (
    input  logic                         i_pclk,
    input  logic                         i_resetn,
    input  logic                         i_enable,
    input  logic [3:0]                   i_frame_skip,
    input  logic                         i_err_clear,
    input  logic                         i_vsync,
    input  logic                         i_href,
    input  logic [7:0]                   i_data,
    output logic [8*BYTES_PER_PIXEL-1:0] M_AXIS_VIDEO_TDATA,
    output logic                         M_AXIS_TVALID,
    input  logic                         M_AXIS_VIDEO_TREADY,
    output logic                         M_AXIS_VIDEO_TUSER,
    output logic                         M_AXIS_VIDEO_TLAST,
    output logic                         o_overflow,
    output logic                         o_sync_err,
    output logic [15:0]                  o_frame_count
);

    localparam int unsigned DATA_W  = 8 * BYTES_PER_PIXEL;
    localparam int unsigned ENTRY_W = entry_width(BYTES_PER_PIXEL);
    localparam int unsigned PIX_W   = (X_RES > 1) ? $clog2(X_RES) : 1;
    localparam int unsigned LINE_W  = (Y_RES > 1) ? $clog2(Y_RES) : 1;
    localparam int unsigned PHASE_W = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;

    localparam logic [PIX_W-1:0]   PIX_LAST   = PIX_W'(X_RES - 1);
    localparam logic [LINE_W-1:0]  LINE_LAST  = LINE_W'(Y_RES - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(BYTES_PER_PIXEL - 1);

    cap_state_e          state_q, state_d;
    logic                vsync_q, href_q;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [3:0]          skip_q, skip_d;
    logic [15:0]         frame_q, frame_d;
    logic [7:0]          hold_q, hold_d;
    logic                overflow_q, overflow_d;
    logic                sync_err_q, sync_err_d;

    logic                vsync_rise, href_fall;
    logic                push, overflow_set, sync_err_set;
    logic [DATA_W-1:0]   pixel;
    logic [ENTRY_W-1:0]  fifo_wdata, fifo_rdata;
    logic                fifo_full, fifo_empty, axis_pop;

    assign vsync_rise = !vsync_q && i_vsync;
    assign href_fall  = href_q && !i_href;
    assign axis_pop   = !fifo_empty && M_AXIS_VIDEO_TREADY;

    if (BYTES_PER_PIXEL == 1) begin : g_bpp1
        assign pixel = i_data;
    end else if (BYTE_ORDER == 0) begin : g_first_low
        assign pixel = {i_data, hold_q};
    end else begin : g_first_high
        assign pixel = {hold_q, i_data};
    end

    assign fifo_wdata = {pixel, (pix_q == '0) && (line_q == '0), pix_q == PIX_LAST};

    always_comb begin
        state_d      = state_q;
        pix_d        = pix_q;
        line_d       = line_q;
        phase_d      = phase_q;
        skip_d       = skip_q;
        frame_d      = frame_q;
        hold_d       = hold_q;
        push         = 1'b0;
        overflow_set = 1'b0;
        sync_err_set = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_SKIP: begin
                if (vsync_rise) begin
                    if (skip_q == '0) begin
                        state_d = ST_ACTIVE;
                        pix_d   = '0;
                        line_d  = '0;
                        phase_d = '0;
                    end else begin
                        skip_d  = skip_q - 1'b1;
                        state_d = ST_SKIP;
                    end
                end
            end
            ST_ACTIVE: begin
                if (vsync_rise) begin
                    // Short frame: restart on the new frame without touching the skip count.
                    sync_err_set = 1'b1;
                    pix_d        = '0;
                    line_d       = '0;
                    phase_d      = '0;
                end else if (href_fall && (pix_q != '0 || phase_q != '0)) begin
                    sync_err_set = 1'b1;
                    state_d      = ST_IDLE;
                end else if (i_href) begin
                    if (phase_q != PHASE_LAST) begin
                        phase_d = phase_q + 1'b1;
                        hold_d  = i_data;
                    end else begin
                        phase_d = '0;
                        if (fifo_full && !axis_pop) begin
                            overflow_set = 1'b1;
                            state_d      = ST_IDLE;
                        end else begin
                            push = 1'b1;
                            if (pix_q == PIX_LAST) begin
                                pix_d = '0;
                                if (line_q == LINE_LAST) begin
                                    line_d  = '0;
                                    frame_d = frame_q + 16'd1;
                                    skip_d  = i_frame_skip;
                                    state_d = ST_IDLE;
                                end else begin
                                    line_d = line_q + 1'b1;
                                end
                            end else begin
                                pix_d = pix_q + 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!i_enable) begin
            state_d      = ST_IDLE;
            pix_d        = '0;
            line_d       = '0;
            phase_d      = '0;
            skip_d       = '0;
            frame_d      = frame_q;
            push         = 1'b0;
            overflow_set = 1'b0;
            sync_err_set = 1'b0;
        end

        overflow_d = (overflow_q && !i_err_clear) || overflow_set;
        sync_err_d = (sync_err_q && !i_err_clear) || sync_err_set;
    end

    always_ff @(posedge i_pclk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q    <= ST_IDLE;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            pix_q      <= '0;
            line_q     <= '0;
            phase_q    <= '0;
            skip_q     <= '0;
            frame_q    <= '0;
            hold_q     <= '0;
            overflow_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vsync_q    <= i_vsync;
            href_q     <= i_href;
            pix_q      <= pix_d;
            line_q     <= line_d;
            phase_q    <= phase_d;
            skip_q     <= skip_d;
            frame_q    <= frame_d;
            hold_q     <= hold_d;
            overflow_q <= overflow_d;
            sync_err_q <= sync_err_d;
        end
    end

    cam_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_pclk   (i_pclk),
        .i_resetn (i_resetn),
        .i_flush  (!i_enable),
        .i_push   (push),
        .i_wdata  (fifo_wdata),
        .i_pop    (axis_pop),
        .o_rdata  (fifo_rdata),
        .o_full   (fifo_full),
        .o_empty  (fifo_empty)
    );

    // Storage is not reset, so the head is masked while empty to keep idle outputs at zero.
    assign M_AXIS_TVALID      = !fifo_empty;
    assign M_AXIS_VIDEO_TDATA = fifo_empty ? '0 : fifo_rdata[ENTRY_DATA_LSB +: DATA_W];
    assign M_AXIS_VIDEO_TUSER = !fifo_empty && fifo_rdata[ENTRY_USER_BIT];
    assign M_AXIS_VIDEO_TLAST = !fifo_empty && fifo_rdata[ENTRY_LAST_BIT];
    assign o_overflow         = overflow_q;
    assign o_sync_err         = sync_err_q;
    assign o_frame_count      = frame_q;

endmodule

// File: tb/tb_cam_capture_maxis_fifo.sv
// Randomized bench for cam_capture_maxis_fifo against a frame-level scoreboard model.
module tb_cam_capture_maxis_fifo;

    localparam int unsigned XR    = 4;
    localparam int unsigned YR    = 2;
    localparam int unsigned BPP   = 2;
    localparam int unsigned BO    = 0;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 8 * BPP;
    localparam int unsigned LBYTES = XR * BPP;

    logic          i_pclk = 1'b0;
    logic          i_resetn = 1'b0;
    logic          i_enable = 1'b0;
    logic [3:0]    i_frame_skip = '0;
    logic          i_err_clear = 1'b0;
    logic          i_vsync = 1'b0;
    logic          i_href = 1'b0;
    logic [7:0]    i_data = '0;
    logic          tready = 1'b0;
    logic [DW-1:0] tdata;
    logic          tvalid, tuser, tlast, overflow, sync_err;
    logic [15:0]   frame_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW+1:0] exp_q[$];
    int exp_count = 0;
    int beats = 0;
    int ready_mode = 0;
    int cyc = 0;
    int b0;

    always #5 i_pclk = ~i_pclk;

    cam_capture_maxis_fifo #(
        .X_RES           (XR),
        .Y_RES           (YR),
        .BYTES_PER_PIXEL (BPP),
        .BYTE_ORDER      (BO),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .i_pclk              (i_pclk),
        .i_resetn            (i_resetn),
        .i_enable            (i_enable),
        .i_frame_skip        (i_frame_skip),
        .i_err_clear         (i_err_clear),
        .i_vsync             (i_vsync),
        .i_href              (i_href),
        .i_data              (i_data),
        .M_AXIS_VIDEO_TDATA  (tdata),
        .M_AXIS_TVALID       (tvalid),
        .M_AXIS_VIDEO_TREADY (tready),
        .M_AXIS_VIDEO_TUSER  (tuser),
        .M_AXIS_VIDEO_TLAST  (tlast),
        .o_overflow          (overflow),
        .o_sync_err          (sync_err),
        .o_frame_count       (frame_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Handshake monitor: inputs change on the falling edge, so values here are what
    // the next rising edge will consume.
    always @(negedge i_pclk) begin
        #1;
        if (i_resetn && i_enable && tvalid && tready) begin
            beats++;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(tvalid), 32'd0);
            end else begin
                logic [DW+1:0] e;
                e = exp_q.pop_front();
                check("tdata", 32'(tdata), 32'(e[DW+1:2]));
                check("tuser", 32'(tuser), 32'(e[1]));
                check("tlast", 32'(tlast), 32'(e[0]));
            end
        end
    end

    task automatic cycle(input logic vs, input logic hr, input logic [7:0] d);
        @(negedge i_pclk);
        i_vsync = vs;
        i_href  = hr;
        i_data  = d;
        cyc++;
        case (ready_mode)
            0:       tready = 1'b1;
            1:       tready = (cyc % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            default: tready = 1'b0;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic vsync_pulse();
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        idle(2);
    endtask

    // Sends nbytes on one href line; the first n_exp complete pixels are expected beats.
    task automatic send_line(input int nbytes, input int line, input int n_exp, input int base);
        logic [7:0] b[$];
        for (int i = 0; i < nbytes; i++) begin
            logic [7:0] d;
            d = (base < 0) ? 8'($urandom) : 8'(base + i);
            b.push_back(d);
            cycle(1'b0, 1'b1, d);
            if ((i % BPP) == BPP - 1 && (i / BPP) < n_exp) begin
                logic [DW-1:0] px;
                int p;
                p = i / BPP;
                for (int k = 0; k < BPP; k++)
                    px[8*k +: 8] = b[BPP*p + ((BO != 0) ? (BPP - 1 - k) : k)];
                exp_q.push_back({px, (line == 0 && p == 0), (p == XR - 1)});
            end
        end
        idle(2);
    endtask

    task automatic send_frame(input bit captured, input int base);
        vsync_pulse();
        for (int l = 0; l < YR; l++)
            send_line(LBYTES, l, captured ? XR : 0, (base < 0) ? -1 : base + l * LBYTES);
        if (captured) exp_count++;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1);
        idle(3);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_tvalid_idle"}, 32'(tvalid), 32'd0);
    endtask

    task automatic err_clear();
        cycle(1'b0, 1'b0, 8'h00);
        i_err_clear = 1'b1;
        cycle(1'b0, 1'b0, 8'h00);
        i_err_clear = 1'b0;
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tvalid"}, 32'(tvalid), 32'd0);
        check({tag, "_tdata"}, 32'(tdata), 32'd0);
        check({tag, "_tuser"}, 32'(tuser), 32'd0);
        check({tag, "_tlast"}, 32'(tlast), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_sync_err"}, 32'(sync_err), 32'd0);
        check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge i_pclk);
        #1;
        check_all_zero("reset");
        @(negedge i_pclk);
        i_resetn = 1'b1;
        i_enable = 1'b1;
        idle(3);

        // Fixed ramp 0x01..0x10 with TREADY high.
        ready_mode = 0;
        send_frame(1'b1, 1);
        drain("ramp");
        check("ramp_frame_count", 32'(frame_count), 32'(exp_count));

        // Random frames with intermittent backpressure.
        ready_mode = 1;
        repeat (3) send_frame(1'b1, -1);
        drain("rand");
        check("rand_frame_count", 32'(frame_count), 32'(exp_count));
        check("rand_overflow", 32'(overflow), 32'd0);
        check("rand_sync_err", 32'(sync_err), 32'd0);

        // Decimation: with skip 2, every third frame is captured.
        i_frame_skip = 4'd2;
        for (int k = 0; k < 6; k++) send_frame((k % 3) == 0, -1);
        i_frame_skip = 4'd0;
        drain("skip");
        check("skip_frame_count", 32'(frame_count), 32'(exp_count));

        // Overflow with TREADY held low: line 0 fills the FIFO, line 1 overflows.
        ready_mode = 2;
        vsync_pulse();
        send_line(LBYTES, 0, DEPTH, -1);
        send_line(LBYTES, 1, 0, -1);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_tvalid_held", 32'(tvalid), 32'd1);
        check("ovf_frame_count", 32'(frame_count), 32'(exp_count));
        b0 = beats;
        ready_mode = 0;
        drain("ovf");
        check("ovf_beats", 32'(beats - b0), 32'(DEPTH));
        send_line(LBYTES, 0, 0, -1);
        idle(3);
        check("ovf_idle_no_beats", 32'(beats - b0), 32'(DEPTH));
        err_clear();
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Short line: href drops after 3 bytes of line 0.
        ready_mode = 1;
        vsync_pulse();
        send_line(3, 0, 1, -1);
        send_line(LBYTES, 1, 0, -1);
        drain("short_line");
        check("short_line_err", 32'(sync_err), 32'd1);
        send_frame(1'b1, -1);
        drain("short_line_next");
        check("short_line_count", 32'(frame_count), 32'(exp_count));
        err_clear();
        check("short_line_cleared", 32'(sync_err), 32'd0);

        // Short frame: vsync after line 0 restarts the frame.
        vsync_pulse();
        send_line(LBYTES, 0, XR, -1);
        vsync_pulse();
        check("short_frame_err", 32'(sync_err), 32'd1);
        check("short_frame_count_hold", 32'(frame_count), 32'(exp_count));
        send_line(LBYTES, 0, XR, -1);
        send_line(LBYTES, 1, XR, -1);
        exp_count++;
        drain("short_frame");
        check("short_frame_count", 32'(frame_count), 32'(exp_count));
        err_clear();

        // Enable low flushes the FIFO and FSM but keeps the frame counter.
        ready_mode = 2;
        vsync_pulse();
        send_line(LBYTES, 0, 0, -1);
        check("flush_pre_tvalid", 32'(tvalid), 32'd1);
        cycle(1'b0, 1'b0, 8'h00);
        i_enable = 1'b0;
        cycle(1'b0, 1'b0, 8'h00);
        i_enable = 1'b1;
        #2;
        check("flush_tvalid", 32'(tvalid), 32'd0);
        check("flush_frame_count", 32'(frame_count), 32'(exp_count));
        ready_mode = 1;
        send_line(LBYTES, 1, 0, -1);
        send_frame(1'b1, -1);
        drain("flush");
        check("flush_next_count", 32'(frame_count), 32'(exp_count));

        // Reset mid-line with three pixels queued.
        ready_mode = 2;
        vsync_pulse();
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 8'($urandom));
        #2;
        check("rst_pre_tvalid", 32'(tvalid), 32'd1);
        @(negedge i_pclk);
        i_resetn = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        exp_count = 0;
        @(negedge i_pclk);
        i_resetn = 1'b1;
        ready_mode = 0;
        b0 = beats;
        send_line(LBYTES, 0, 0, -1);
        idle(3);
        check("rst_no_capture", 32'(beats - b0), 32'd0);
        send_frame(1'b1, -1);
        drain("rst");
        check("rst_frame_count", 32'(frame_count), 32'(exp_count));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cam_capture_maxis_fifo.md
# cam_capture_maxis_fifo

Parametrised camera-capture front end. It samples an 8-bit parallel DVP sensor bus (OV7670-class) in the sensor pixel-clock domain and assembles 1- or 2-byte pixels. It pushes them through an internal elastic FIFO onto an AXI4-Stream video master that honours TREADY. It sits between the sensor pins and the video DMA / VDMA input, adding frame decimation, overflow and line/frame error detection, and a frame counter.

## Interface
- X_RES, 640, active pixels per line
- Y_RES, 480, active lines per frame
- BYTES_PER_PIXEL, 2, 1 or 2 sensor bytes per pixel
- BYTE_ORDER, 0, 0: first byte -> TDATA[7:0]; 1: first byte -> TDATA[15:8] (ignored when BYTES_PER_PIXEL=1)
- FIFO_DEPTH, 16, power of two, >= 4
- i_pclk  in  1  pixel clock, sole clock
- i_resetn  in  1  asynchronous active-low reset
- i_enable  in  1  capture enable; low = synchronous flush
- i_frame_skip  in  4  frames discarded after each captured frame (0 = capture all)
- i_err_clear  in  1  synchronous clear of sticky error flags
- i_vsync  in  1  active-high vsync
- i_href  in  1  active-high line valid
- i_data  in  8  sensor data
- M_AXIS_VIDEO_TDATA  out  8*BYTES_PER_PIXEL  pixel
- M_AXIS_TVALID  out  1  FIFO non-empty
- M_AXIS_VIDEO_TREADY  in  1  downstream ready
- M_AXIS_VIDEO_TUSER  out  1  start of frame (pixel 0, line 0)
- M_AXIS_VIDEO_TLAST  out  1  end of line (pixel X_RES-1)
- o_overflow  out  1  sticky: pixel arrived with FIFO full
- o_sync_err  out  1  sticky: short line or short frame
- o_frame_count  out  16  completed captured frames, wraps at 0xFFFF -> 0

## Operation
- Reset: all outputs 0, FSM ST_IDLE, FIFO empty, counters 0, skip counter 0.
- vsync rising edge = registered i_vsync low and i_vsync high; href falling edge = registered i_href high and i_href low.
- States: ST_IDLE, ST_SKIP, ST_ACTIVE.
- ST_IDLE:
  - On vsync rising edge with skip counter 0: -> ST_ACTIVE. Pixel, line and byte counters are cleared.
  - On vsync rising edge with skip counter non-zero: decrement the skip counter and -> ST_SKIP.
- ST_SKIP: ignores data; returns to ST_IDLE on the next vsync rising edge, which is evaluated as in ST_IDLE in the same cycle.
- ST_ACTIVE, while i_href = 1:
  - Each edge captures one byte. The byte phase toggles modulo BYTES_PER_PIXEL.
  - On the final byte, push {pixel, TUSER, TLAST} into the FIFO. TUSER = (pixel==0 && line==0); TLAST = (pixel==X_RES-1).
  - After pixel X_RES-1 of line Y_RES-1: increment o_frame_count, load the skip counter from i_frame_skip, -> ST_IDLE.
- Overflow: push while FIFO full drops the pixel, sets o_overflow and aborts the frame (-> ST_IDLE). Entries already in the FIFO still drain.
- Short line: an href falling edge in ST_ACTIVE with pixel counter != 0 or byte phase != 0 sets o_sync_err and aborts the frame (-> ST_IDLE).
- Short frame: a vsync rising edge in ST_ACTIVE sets o_sync_err and restarts capture in ST_ACTIVE with counters cleared. The skip counter is not reloaded.
- Sticky flags clear only on i_err_clear or reset. If i_err_clear coincides with a new error event, the flag ends set.
- i_enable low, taking priority over all events:
  - FSM -> ST_IDLE, counters and FIFO cleared, TVALID 0 the next cycle.
  - Sticky flags and o_frame_count hold.

## Timing
- FIFO is first-word-fall-through. Outputs are the FIFO head, so TDATA/TUSER/TLAST are stable while TVALID && !TREADY.
- Latency, empty FIFO: TVALID rises in the cycle after the edge that samples the pixel's final byte.
- Pop occurs on TVALID && TREADY. A simultaneous push and pop when full is not an overflow (pop first).
- Throughput is one pixel per BYTES_PER_PIXEL clocks. With TREADY held high the FIFO never exceeds 1 entry.
- Counter widths: $clog2(X_RES), $clog2(Y_RES), 4-bit skip, 16-bit frame; byte phase uses $clog2 of BYTES_PER_PIXEL, minimum 1 bit.
- The only permitted AXIS protocol break is an i_enable low mid-handshake, where TVALID may drop without TREADY.

## Structure
- Package cam_capture_pkg holds:
  - the state enum: ST_IDLE, ST_SKIP, ST_ACTIVE;
  - a parametrised FIFO entry layout: data, user, last;
  - the AXIS sideband bit widths.
- Sub-module cam_sync_fifo: single-clock FWFT FIFO with synchronous flush and full/empty outputs, WIDTH and DEPTH parameters.
- Top level contains the edge detectors, the FSM, pixel assembly, the error logic and the frame counter.

## Test plan
All scenarios use X_RES=4, Y_RES=2, BYTES_PER_PIXEL=2, BYTE_ORDER=0, TREADY=1 unless stated.
- Bytes 0x01..0x10 over 2 lines -> TDATA 0x0201, 0x0403, …, 0x100F. TUSER on the first beat only, TLAST on beats 4 and 8, o_frame_count=1.
- i_frame_skip=2, 6 frames -> frames 1 and 4 captured, o_frame_count=2, no beats from frames 2, 3, 5, 6.
- TREADY held low, FIFO_DEPTH=4, one frame -> 4 beats retained, o_overflow=1, FSM in ST_IDLE. Raising TREADY then yields exactly those 4 beats unchanged.
- href drops after 3 bytes of line 0 -> o_sync_err=1, no partial pixel emitted, next frame captured cleanly after vsync. i_err_clear then gives o_sync_err=0.
- vsync rising edge after line 0 -> o_sync_err=1, the next pixel carries TUSER=1, o_frame_count unchanged until a full frame completes.
- i_resetn pulsed low mid-line with FIFO holding 3 entries -> all outputs 0 immediately, and capture resumes only after the next vsync rising edge.
